// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out transmitter. A WIDTH-bit word is taken through a
// valid/ready handshake and sent one bit per clock on Serial_OUT, framed by
// Shift_EN. Shift_EN is meant to drive a downstream serial-in shift
// register's enable directly. Consecutive words are sent with no idle gap.
//
// Handshake: a word transfers at a rising CLK edge where
//   Data_Valid && Data_Ready. Data_Ready depends only on internal state
//   (never on Data_Valid). A source whose word is not accepted must hold it.
//   Data_IN is sampled only at the transfer edge.
//
// Ports
//   CLK         in   clock, rising edge
//   RST_N       in   synchronous active-low reset
//   Data_IN     in   [WIDTH-1:0] word to send
//   Data_Valid  in   Data_IN is valid
//   Data_Ready  out  a word can be accepted this cycle
//                    (idle, or the last bit of the current word)
//   Serial_OUT  out  registered serial data, 0 when idle
//   Shift_EN    out  registered, high while Serial_OUT carries a valid bit
//   Busy        out  high in SHIFT state (mirrors the FSM state)
//   Done        out  high during the last bit of each word
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] Data_IN,
  input  logic             Data_Valid,
  output logic             Data_Ready,
  output logic             Serial_OUT,
  output logic             Shift_EN,
  output logic             Busy,
  output logic             Done
);

  localparam int             CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
  localparam int             OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             serial_q, serial_d;
  logic             shift_en_q, shift_en_d;

  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      serial_q   <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      serial_q   <= serial_d;
      shift_en_q <= shift_en_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    // Shift toward the output end with zero fill.
    shifted = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
    accept  = Data_Valid && Data_Ready;

    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SHIFT;
          shift_d = Data_IN;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        if (!last_bit) begin
          shift_d = shifted;
          cnt_d   = cnt_q + 1'b1;
        end else if (accept) begin
          // Gapless reload: next word's first bit follows the last bit.
          shift_d = Data_IN;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Serial_OUT and Shift_EN are registered copies of what the next state
    // will present, so they line up with Busy/Done decoded from the flops.
    shift_en_d = (state_d == S_SHIFT);
    serial_d   = (state_d == S_SHIFT) ? shift_d[OUT_IDX] : 1'b0;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    last_bit   = (state_q == S_SHIFT) && (cnt_q == LAST);
    Data_Ready = (state_q == S_IDLE) || last_bit;
    Busy       = (state_q == S_SHIFT);
    Done       = last_bit;
    Serial_OUT = serial_q;
    Shift_EN   = shift_en_q;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//
// Two instances share one set of inputs: dut_m sends MSB first, dut_l LSB
// first. Each drives a pair of loopback receivers (one shifting into the LSB
// end, one into the MSB end).
// A queue-of-bits reference model predicts every output every cycle; table
// vectors and hand-written sequences cover the directed scenarios.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W = 4;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] data_in;
  logic         data_valid;

  logic ready_m, ser_m, en_m, busy_m, done_m;
  logic ready_l, ser_l, en_l, busy_l, done_l;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .CLK        (clk),
    .RST_N      (rst_n),
    .Data_IN    (data_in),
    .Data_Valid (data_valid),
    .Data_Ready (ready_m),
    .Serial_OUT (ser_m),
    .Shift_EN   (en_m),
    .Busy       (busy_m),
    .Done       (done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .CLK        (clk),
    .RST_N      (rst_n),
    .Data_IN    (data_in),
    .Data_Valid (data_valid),
    .Data_Ready (ready_l),
    .Serial_OUT (ser_l),
    .Shift_EN   (en_l),
    .Busy       (busy_l),
    .Done       (done_l)
  );

  // -------------------------------------------------------------------------
  // Loopback receivers
  // -------------------------------------------------------------------------
  logic [W-1:0] rx_l_m, rx_r_m, rx_l_l, rx_r_l;

  always @(posedge clk) begin
    if (!rst_n) begin
      rx_l_m <= '0;
      rx_r_m <= '0;
      rx_l_l <= '0;
      rx_r_l <= '0;
    end else begin
      if (en_m) begin
        rx_l_m <= {rx_l_m[W-2:0], ser_m};
        rx_r_m <= {ser_m, rx_r_m[W-1:1]};
      end
      if (en_l) begin
        rx_l_l <= {rx_l_l[W-2:0], ser_l};
        rx_r_l <= {ser_l, rx_r_l[W-1:1]};
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: every accepted word appends its bits, in transmit
  // order, to a queue; each clock with a bit on the line retires one.
  // A word is accepted when the queue holds at most one bit (idle or last
  // bit) and reset is not asserted.
  // -------------------------------------------------------------------------
  logic [0:0] exp_q_m[$];
  logic [0:0] exp_q_l[$];
  bit         model_en = 1'b0;

  always @(posedge clk) begin
    if (model_en) begin
      if (!rst_n) begin
        exp_q_m.delete();
        exp_q_l.delete();
      end else if (data_valid && exp_q_m.size() <= 1) begin
        if (exp_q_m.size() == 1) begin
          void'(exp_q_m.pop_front());
          void'(exp_q_l.pop_front());
        end
        for (int b = 0; b < W; b++) begin
          exp_q_m.push_back(data_in[W-1-b]);
          exp_q_l.push_back(data_in[b]);
        end
      end else if (exp_q_m.size() > 0) begin
        void'(exp_q_m.pop_front());
        void'(exp_q_l.pop_front());
      end
    end
  end

  // {Data_Ready, Serial_OUT, Shift_EN, Busy, Done}
  function automatic logic [7:0] exp_pack(input int sz, input logic fb);
    return {3'b000, (sz <= 1), (sz > 0) && fb, (sz > 0), (sz > 0), (sz == 1)};
  endfunction

  always @(negedge clk) begin
    if (model_en) begin
      check("model_msb", {3'b000, ready_m, ser_m, en_m, busy_m, done_m},
            exp_pack(exp_q_m.size(), exp_q_m.size() > 0 ? exp_q_m[0] : 1'b0));
      check("model_lsb", {3'b000, ready_l, ser_l, en_l, busy_l, done_l},
            exp_pack(exp_q_l.size(), exp_q_l.size() > 0 ? exp_q_l[0] : 1'b0));
    end
  end

  // -------------------------------------------------------------------------
  // Directed vectors. Streams are in time order: bit [3] is sent first.
  // A receiver shifting into its LSB end ends up holding the stream as
  // written; one shifting into its MSB end holds it reversed.
  // -------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] msb_stream;
    logic [W-1:0] lsb_stream;
  } vec_t;

  vec_t vecs[8];

  task automatic send_vec(input vec_t v);
    data_in    = v.din;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    data_in    = W'($urandom);  // word in flight must be unaffected
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("vec_ser_msb", 8'(ser_m), 8'(v.msb_stream[W-1-i]));
      check("vec_ser_lsb", 8'(ser_l), 8'(v.lsb_stream[W-1-i]));
      check("vec_shift_en", 8'(en_m), 8'd1);
      check("vec_done", 8'(done_m), 8'(i == W - 1));
      check("vec_ready", 8'(ready_m), 8'(i == W - 1));
    end
    @(negedge clk);
    check("vec_idle_en", 8'({en_m, en_l}), 8'd0);
    check("vec_idle_ser", 8'({ser_m, ser_l}), 8'd0);
    check("loop_left_msb", 8'(rx_l_m), 8'(v.msb_stream));
    check("loop_right_msb", 8'(rx_r_m), 8'(v.lsb_stream));
    check("loop_left_lsb", 8'(rx_l_l), 8'(v.lsb_stream));
    check("loop_right_lsb", 8'(rx_r_l), 8'(v.din));
    @(negedge clk);
    check("loop_hold", 8'(rx_l_m), 8'(v.msb_stream));
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  logic [7:0] stream_m, stream_l;

  initial begin
    vecs[0] = '{4'b1011, 4'b1011, 4'b1101};
    vecs[1] = '{4'b0110, 4'b0110, 4'b0110};
    vecs[2] = '{4'b0001, 4'b0001, 4'b1000};
    vecs[3] = '{4'b1101, 4'b1101, 4'b1011};
    vecs[4] = '{4'b1010, 4'b1010, 4'b0101};
    vecs[5] = '{4'b1111, 4'b1111, 4'b1111};
    vecs[6] = '{4'b0000, 4'b0000, 4'b0000};
    vecs[7] = '{4'b1000, 4'b1000, 4'b0001};

    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ser", 8'({ser_m, ser_l}), 8'd0);
    check("rst_shift_en", 8'({en_m, en_l}), 8'd0);
    check("rst_busy", 8'({busy_m, busy_l}), 8'd0);
    check("rst_done", 8'({done_m, done_l}), 8'd0);
    check("rst_ready", 8'({ready_m, ready_l}), 8'b11);
    model_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors (includes the loopback word 1101)
    for (int k = 0; k < 8; k++) send_vec(vecs[k]);

    // Back-to-back: 1011 then 0110 held valid, no gap
    stream_m   = 8'b1011_0110;
    stream_l   = 8'b1101_0110;
    data_in    = 4'b1011;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_ser_msb", 8'(ser_m), 8'(stream_m[7-i]));
      check("b2b_ser_lsb", 8'(ser_l), 8'(stream_l[7-i]));
      check("b2b_shift_en", 8'(en_m), 8'd1);
      check("b2b_done", 8'(done_m), 8'(i == 3 || i == 7));
      check("b2b_ready", 8'(ready_m), 8'(i == 3 || i == 7));
      if (i == 3) begin
        @(posedge clk);
        #1;
        data_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_end_en", 8'(en_m), 8'd0);

    // Busy stall: 1111 offered during the 2nd bit of 0001
    stream_m   = 8'b0001_1111;
    stream_l   = 8'b1000_1111;
    data_in    = 4'b0001;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stall_ser_msb", 8'(ser_m), 8'(stream_m[7-i]));
      check("stall_ser_lsb", 8'(ser_l), 8'(stream_l[7-i]));
      check("stall_shift_en", 8'(en_m), 8'd1);
      check("stall_ready", 8'(ready_m), 8'(i == 3 || i == 7));
      if (i == 0) begin
        @(posedge clk);
        #1;
        data_valid = 1'b1;
        data_in    = 4'b1111;
      end
      if (i == 3) begin
        @(posedge clk);
        #1;
        data_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("stall_end_en", 8'(en_m), 8'd0);

    // Reset mid-word at the 2nd bit of 1010, then a word offered in reset
    data_in    = 4'b1010;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    @(negedge clk);
    check("mid_bit0", 8'(ser_m), 8'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_bit1", 8'(ser_m), 8'd0);
    check("mid_bit1_en", 8'(en_m), 8'd1);
    @(posedge clk);
    #1;
    data_valid = 1'b1;
    data_in    = 4'b1111;
    @(negedge clk);
    check("mid_rst_outs", 8'({ser_m, en_m, busy_m, done_m, ready_m}), 8'b00001);
    check("mid_rst_outs_l", 8'({ser_l, en_l, busy_l, done_l, ready_l}), 8'b00001);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    data_valid = 1'b0;
    @(negedge clk);
    check("rst_priority_en", 8'({en_m, busy_m}), 8'd0);
    send_vec(vecs[3]);

    // Randomized traffic against the model, with occasional reset
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      rst_n      = ($urandom_range(0, 49) != 0);
      data_valid = ($urandom_range(0, 9) < 7);
      data_in    = W'($urandom);
    end
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    data_valid = 1'b0;
    repeat (W + 2) @(posedge clk);
    @(negedge clk);
    check("final_idle", 8'({en_m, en_l, busy_m, busy_l}), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
